// File: rtl/session_pkg.sv
// Shared state encoding and default timing constants for the drum-song session sequencer.
package session_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TICK_W  = 25;

  localparam int unsigned DEF_TICKS_PER_SEC  = 27000000;
  localparam int unsigned DEF_COUNTDOWN_SECS = 3;
  localparam int unsigned DEF_MAX_SONG_SECS  = 180;
  localparam int unsigned DEF_NUM_SONGS      = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_DONE      = 3'd4
  } session_state_e;

endpackage

// File: rtl/song_session_ctrl_if.sv
// Player-button, song-timer and display signals of one session controller.
interface song_session_ctrl_if;
  import session_pkg::*;

  logic               btn_start;
  logic               btn_pause;
  logic               btn_quit;
  logic               btn_next;
  logic               song_done;
  logic [7:0]         seconds_elap;

  logic               start_song;
  logic               pause_song;
  logic [1:0]         song_sel;
  logic [3:0]         countdown;
  logic [STATE_W-1:0] state;
  logic               session_end;
  logic               timed_out;

  modport master (
    output btn_start, btn_pause, btn_quit, btn_next, song_done, seconds_elap,
    input  start_song, pause_song, song_sel, countdown, state, session_end, timed_out
  );

  modport slave (
    input  btn_start, btn_pause, btn_quit, btn_next, song_done, seconds_elap,
    output start_song, pause_song, song_sel, countdown, state, session_end, timed_out
  );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts 0..TICKS_PER_SEC-1 while enabled, pulses on the last count.
module sec_tick_gen
  import session_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [TICK_W-1:0] LastCount = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LastCount);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/song_session_ctrl.sv
// Session sequencer: song select, pre-roll countdown, song timer control and time limit.
module song_session_ctrl
  import session_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC  = DEF_TICKS_PER_SEC,
  parameter int unsigned COUNTDOWN_SECS = DEF_COUNTDOWN_SECS,
  parameter int unsigned MAX_SONG_SECS  = DEF_MAX_SONG_SECS,
  parameter int unsigned NUM_SONGS      = DEF_NUM_SONGS
) (
  input logic               clk,
  input logic               reset,
  song_session_ctrl_if.slave bus
);

  localparam logic [3:0] CountdownInit = 4'(COUNTDOWN_SECS);
  localparam logic [7:0] MaxSecs       = 8'(MAX_SONG_SECS);
  localparam logic [1:0] LastSong      = 2'(NUM_SONGS - 1);

  session_state_e state_q, state_d;
  logic [1:0]     song_sel_q, song_sel_d;
  logic [3:0]     countdown_q, countdown_d;
  logic           start_song_q, start_song_d;
  logic           pause_song_q, pause_song_d;
  logic           session_end_q, session_end_d;
  logic           timed_out_q, timed_out_d;

  logic           tick;
  logic           tick_clr;
  logic           done_eff;
  logic           time_up;

  // Counter restarts on every state entry so each countdown second is full length.
  assign tick_clr = (state_d != state_q);

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .en   (state_q == ST_COUNTDOWN),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    song_sel_d   = song_sel_q;
    countdown_d  = countdown_q;
    timed_out_d  = timed_out_q;
    start_song_d = 1'b0;
    // Song memory restarts on start_song, so a stale done flag that cycle is dropped.
    done_eff     = bus.song_done && !start_song_q;
    time_up      = (bus.seconds_elap >= MaxSecs);

    case (state_q)
      ST_IDLE: begin
        if (bus.btn_start) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = CountdownInit;
          timed_out_d = 1'b0;
        end else if (bus.btn_next) begin
          song_sel_d = (song_sel_q == LastSong) ? 2'd0 : song_sel_q + 2'd1;
        end
      end
      ST_COUNTDOWN: begin
        if (bus.btn_quit) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (countdown_q <= 4'd1) begin
            state_d      = ST_PLAYING;
            start_song_d = 1'b1;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end
      ST_PLAYING: begin
        if (bus.btn_quit) begin
          state_d = ST_IDLE;
        end else if (done_eff || time_up) begin
          state_d     = ST_DONE;
          timed_out_d = time_up && !done_eff;
        end else if (bus.btn_pause) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (bus.btn_quit) begin
          state_d = ST_IDLE;
        end else if (bus.btn_start) begin
          state_d = ST_PLAYING;
        end
      end
      ST_DONE: begin
        if (bus.btn_quit) begin
          state_d = ST_IDLE;
        end else if (bus.btn_start) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = CountdownInit;
          timed_out_d = 1'b0;
        end else if (bus.btn_next) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != ST_COUNTDOWN) begin
      countdown_d = 4'd0;
    end
    pause_song_d  = (state_d != ST_PLAYING);
    session_end_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      song_sel_q    <= 2'd0;
      countdown_q   <= 4'd0;
      start_song_q  <= 1'b0;
      pause_song_q  <= 1'b1;
      session_end_q <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      song_sel_q    <= song_sel_d;
      countdown_q   <= countdown_d;
      start_song_q  <= start_song_d;
      pause_song_q  <= pause_song_d;
      session_end_q <= session_end_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.song_sel    = song_sel_q;
  assign bus.countdown   = countdown_q;
  assign bus.start_song  = start_song_q;
  assign bus.pause_song  = pause_song_q;
  assign bus.session_end = session_end_q;
  assign bus.timed_out   = timed_out_q;

endmodule

// File: tb/tb_song_session_ctrl.sv
// Scoreboard bench for song_session_ctrl with shortened timing (10 ticks/s, 3 s pre-roll, 5 s limit).
module tb_song_session_ctrl;

  localparam int unsigned TPS  = 10;
  localparam int unsigned CDS  = 3;
  localparam int unsigned MAXS = 5;
  localparam int unsigned NS   = 4;

  localparam int S_IDLE = 0;
  localparam int S_CD   = 1;
  localparam int S_PLAY = 2;
  localparam int S_PAUS = 3;
  localparam int S_DONE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  song_session_ctrl_if bus ();

  song_session_ctrl #(
    .TICKS_PER_SEC (TPS),
    .COUNTDOWN_SECS(CDS),
    .MAX_SONG_SECS (MAXS),
    .NUM_SONGS     (NS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [12:0] obs;
  logic [1:0]  exp_sel = 2'd0;

  // Packed view: {state, countdown, song_sel, start_song, pause_song, session_end, timed_out}
  function automatic logic [12:0] mk(int st, int cd, logic ss, logic ps, logic se, logic to);
    return {3'(st), 4'(cd), exp_sel, ss, ps, se, to};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    obs = {bus.state, bus.countdown, bus.song_sel, bus.start_song, bus.pause_song,
           bus.session_end, bus.timed_out};
  endtask

  task automatic clear_inputs();
    bus.btn_start    = 1'b0;
    bus.btn_pause    = 1'b0;
    bus.btn_quit     = 1'b0;
    bus.btn_next     = 1'b0;
    bus.song_done    = 1'b0;
    bus.seconds_elap = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    exp_sel = 2'd0;
    sb.push_back('{"reset", mk(S_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b0)});
    step();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
    end
    reset = 1'b0;
  endtask

  task automatic test_next_idle();
    for (int i = 0; i < 5; i++) begin
      bus.btn_next = 1'b1;
      exp_sel = 2'((exp_sel + 1) % NS);
      sb.push_back('{$sformatf("next_idle%0d", i), mk(S_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b0)});
      step();
      bus.btn_next = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  // Start pulse at k=1; countdown 3/2/1 for ten cycles each, PLAYING with start_song at k=31.
  task automatic test_countdown(input string name);
    int cd;
    for (int k = 1; k <= 31; k++) begin
      bus.btn_start = (k == 1);
      cd = (k <= 10) ? 3 : (k <= 20) ? 2 : 1;
      if (k <= 30) sb.push_back('{$sformatf("%s_k%0d", name, k),
                                  mk(S_CD, cd, 1'b0, 1'b1, 1'b0, 1'b0)});
      else sb.push_back('{$sformatf("%s_k%0d", name, k), mk(S_PLAY, 0, 1'b1, 1'b0, 1'b0, 1'b0)});
      step();
      bus.btn_start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [1:0] stim [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00};  // {pause, start}
    int         st   [5] = '{S_PAUS, S_PAUS, S_PLAY, S_PLAY, S_PLAY};
    for (int i = 0; i < 5; i++) begin
      bus.btn_pause = stim[i][1];
      bus.btn_start = stim[i][0];
      bus.btn_next  = (i == 4);
      sb.push_back('{$sformatf("pause_resume%0d", i),
                     mk(st[i], 0, 1'b0, st[i] != S_PLAY, 1'b0, 1'b0)});
      step();
      clear_inputs();
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) begin
      bus.seconds_elap = (i == 0) ? 8'(MAXS) : 8'd0;
      if (i < 2) sb.push_back('{$sformatf("timeout%0d", i),
                                mk(S_DONE, 0, 1'b0, 1'b1, i == 0, 1'b1)});
      else sb.push_back('{"timeout_idle", mk(S_DONE, 0, 1'b0, 1'b1, 1'b0, 1'b1)});
      step();
      clear_inputs();
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  // song_done while start_song is high is dropped; then done together with timeout.
  task automatic test_done_and_timeout();
    for (int i = 0; i < 3; i++) begin
      bus.song_done    = (i < 2);
      bus.seconds_elap = (i == 1) ? 8'(MAXS) : 8'd0;
      if (i == 0) sb.push_back('{"done_ignored", mk(S_PLAY, 0, 1'b0, 1'b0, 1'b0, 1'b0)});
      else sb.push_back('{$sformatf("done_both%0d", i), mk(S_DONE, 0, 1'b0, 1'b1, i == 1, 1'b0)});
      step();
      clear_inputs();
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_quit_from_done();
    bus.btn_quit = 1'b1;
    sb.push_back('{"quit_done", mk(S_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b0)});
    step();
    clear_inputs();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
    end
  endtask

  task automatic test_quit_pause();
    for (int i = 0; i < 2; i++) begin
      bus.btn_quit  = (i == 0);
      bus.btn_pause = (i == 0);
      sb.push_back('{$sformatf("quit_pause%0d", i), mk(S_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b0)});
      step();
      clear_inputs();
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  // Quit during countdown, then reset during countdown clears everything including song_sel.
  task automatic test_abort_countdown();
    for (int i = 0; i < 9; i++) begin
      bus.btn_start = (i == 0) || (i == 2);
      bus.btn_quit  = (i == 1);
      reset         = (i == 7);
      if (i == 7) exp_sel = 2'd0;
      if (i == 1 || i >= 7) sb.push_back('{$sformatf("abort%0d", i),
                                           mk(S_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b0)});
      else sb.push_back('{$sformatf("abort%0d", i), mk(S_CD, 3, 1'b0, 1'b1, 1'b0, 1'b0)});
      step();
      clear_inputs();
      reset = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_next_idle();
    test_countdown("cd_first");
    test_pause_resume();
    test_timeout();
    test_countdown("cd_from_done");
    test_done_and_timeout();
    test_quit_from_done();
    test_countdown("cd_third");
    test_quit_pause();
    test_abort_countdown();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
